// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front-end and its arithmetic unit wrappers:
// opcodes, error codes and the sequencer state encoding.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DISPATCH = 2'b01,
        ST_WAIT     = 2'b10,
        ST_RESP     = 2'b11
    } state_t;

endpackage

// File: rtl/calc_timeout_ctr.sv
// Cycle counter that flags when a blocked dispatch/wait has lasted MAX cycles.
// Only instantiated when CALC_TIMEOUT_EN is defined.
module calc_timeout_ctr #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = ($clog2(MAX + 1) > 8) ? $clog2(MAX + 1) : 8;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == CW'(MAX));

    // Saturates at MAX so expired stays asserted until the owner clears it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: runs ADD/SUB locally, dispatches MUL/DIV to the shared units.
// Define CALC_TIMEOUT_EN to abort dispatch/wait after TMO_CYCLES with ERR_TMO.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           REQ,
    input  logic [1:0]     OP,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           BUSY,
    output logic           VALID,
    output logic [2*W-1:0] RESULT,
    output logic [1:0]     ERR,
    output logic [W-1:0]   OPA,
    output logic [W-1:0]   OPB,
    output logic           MUL_START,
    input  logic           MUL_DONE,
    input  logic [2*W-1:0] MUL_P,
    output logic           DIV_START,
    input  logic           DIV_DONE,
    input  logic [W-1:0]   DIV_Q,
    input  logic [W-1:0]   DIV_R
);

    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("TMO_CYCLES must be positive");
    end

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [2*W-1:0]   result_q, result_d;
    logic [1:0]       err_q, err_d;
    logic             mul_done_q, div_done_q;

    logic             sel_done;
    logic             sel_rise;
    logic             tmo_expired;
    logic [W-1:0]     diff;
    logic [2*W-1:0]   sum_ext;
    logic [2*W-1:0]   diff_ext;

    assign diff     = A - B;
    assign sum_ext  = {{W{1'b0}}, A} + {{W{1'b0}}, B};
    assign diff_ext = {{W{diff[W-1]}}, diff};

    // A DONE level left over from an earlier job must not end WAIT; only a fresh rise does.
    assign sel_done = (op_q == OP_DIV) ? DIV_DONE : MUL_DONE;
    assign sel_rise = sel_done & ~((op_q == OP_DIV) ? div_done_q : mul_done_q);

`ifdef CALC_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;

    assign tmo_clear  = (state_q == ST_IDLE) || (state_q == ST_RESP) ||
                        ((state_q == ST_DISPATCH) && !sel_done);
    assign tmo_enable = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);

    calc_timeout_ctr #(
        .MAX(TMO_CYCLES)
    ) u_timeout_ctr (
        .clk     (CLK),
        .rst     (RST),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        err_d     = err_q;
        MUL_START = 1'b0;
        DIV_START = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    op_d  = OP;
                    opa_d = A;
                    opb_d = B;
                    case (OP)
                        OP_ADD: begin
                            result_d = sum_ext;
                            err_d    = ERR_NONE;
                            state_d  = ST_RESP;
                        end
                        OP_SUB: begin
                            result_d = diff_ext;
                            err_d    = ERR_NONE;
                            state_d  = ST_RESP;
                        end
                        OP_MUL: state_d = ST_DISPATCH;
                        default: begin
                            if (B == '0) begin
                                result_d = '0;
                                err_d    = ERR_DIV0;
                                state_d  = ST_RESP;
                            end else begin
                                state_d = ST_DISPATCH;
                            end
                        end
                    endcase
                end
            end
            ST_DISPATCH: begin
                if (sel_done) begin
                    if (tmo_expired) begin
                        result_d = '0;
                        err_d    = ERR_TMO;
                        state_d  = ST_RESP;
                    end
                end else begin
                    if (op_q == OP_DIV) begin
                        DIV_START = 1'b1;
                    end else begin
                        MUL_START = 1'b1;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sel_rise) begin
                    result_d = (op_q == OP_DIV) ? {DIV_R, DIV_Q} : MUL_P;
                    err_d    = ERR_NONE;
                    state_d  = ST_RESP;
                end else if (tmo_expired) begin
                    result_d = '0;
                    err_d    = ERR_TMO;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            opa_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            err_q      <= ERR_NONE;
            mul_done_q <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            err_q      <= err_d;
            mul_done_q <= MUL_DONE;
            div_done_q <= DIV_DONE;
        end
    end

    assign BUSY   = (state_q != ST_IDLE);
    assign VALID  = (state_q == ST_RESP);
    assign RESULT = result_q;
    assign ERR    = err_q;
    assign OPA    = opa_q;
    assign OPB    = opb_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with behavioural multiplier/divider models.
// Define CALC_TIMEOUT_EN to exercise the timeout path in the reset/MUL scenario.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int W   = 8;
    localparam int TMO = 255;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           REQ = 1'b0;
    logic [1:0]     OP  = 2'b00;
    logic [W-1:0]   A   = '0;
    logic [W-1:0]   B   = '0;
    logic           BUSY, VALID, MUL_START, DIV_START;
    logic [2*W-1:0] RESULT;
    logic [1:0]     ERR;
    logic [W-1:0]   OPA, OPB;
    logic           MUL_DONE = 1'b0;
    logic [2*W-1:0] MUL_P    = '0;
    logic           DIV_DONE = 1'b0;
    logic [W-1:0]   DIV_Q    = '0;
    logic [W-1:0]   DIV_R    = '0;

    typedef struct packed {
        logic [2*W-1:0] result;
        logic [1:0]     err;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   valid_cnt  = 0;
    int   mul_starts = 0;
    int   div_starts = 0;
    logic mul_hang   = 1'b0;

    calc_op_sequencer #(.W(W), .TMO_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT), .ERR(ERR),
        .OPA(OPA), .OPB(OPB),
        .MUL_START(MUL_START), .MUL_DONE(MUL_DONE), .MUL_P(MUL_P),
        .DIV_START(DIV_START), .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q), .DIV_R(DIV_R)
    );

    always #5 CLK = ~CLK;

    // Divider model: DONE rises 12 cycles after START and stays high 21 cycles.
    logic [W-1:0] div_a = '0, div_b = '0;
    int div_dly = 0, div_hold = 0;
    always @(posedge CLK) begin
        if (DIV_START === 1'b1) begin
            div_a   <= OPA;
            div_b   <= OPB;
            div_dly <= 11;
        end else if (div_dly != 0) begin
            div_dly <= div_dly - 1;
            if (div_dly == 1) begin
                DIV_DONE <= 1'b1;
                div_hold <= 21;
                DIV_Q    <= div_a / div_b;
                DIV_R    <= div_a % div_b;
            end
        end
        if (DIV_DONE) begin
            if (div_hold == 1) DIV_DONE <= 1'b0;
            div_hold <= div_hold - 1;
        end
    end

    // Multiplier model: DONE rises 4 cycles after START for 2 cycles, or never when hung.
    int mul_dly = 0, mul_hold = 0;
    logic [2*W-1:0] mul_a16 = '0, mul_b16 = '0;
    always @(posedge CLK) begin
        if (MUL_START === 1'b1 && !mul_hang) begin
            mul_a16 <= {{W{1'b0}}, OPA};
            mul_b16 <= {{W{1'b0}}, OPB};
            mul_dly <= 3;
        end else if (mul_dly != 0) begin
            mul_dly <= mul_dly - 1;
            if (mul_dly == 1) begin
                MUL_DONE <= 1'b1;
                mul_hold <= 2;
                MUL_P    <= mul_a16 * mul_b16;
            end
        end
        if (MUL_DONE) begin
            if (mul_hold == 1) MUL_DONE <= 1'b0;
            mul_hold <= mul_hold - 1;
        end
    end

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (MUL_START === 1'b1) mul_starts++;
            if (DIV_START === 1'b1) div_starts++;
            if (MUL_START === 1'b1 || DIV_START === 1'b1) begin
                checks++;
                if ((MUL_START === 1'b1 && DIV_START === 1'b1) || BUSY !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL start_exclusive: MUL_START=%b DIV_START=%b BUSY=%b, required one START while BUSY",
                             MUL_START, DIV_START, BUSY);
                end
            end
            if (VALID === 1'b1) begin
                valid_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_valid: RESULT=%h ERR=%b with no response expected", RESULT, ERR);
                end else begin
                    e = exp_q.pop_front();
                    if (RESULT !== e.result || ERR !== e.err) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: RESULT=%h ERR=%b, expected RESULT=%h ERR=%b",
                                 RESULT, ERR, e.result, e.err);
                    end
                end
            end
        end
    endtask

    // Leaves the caller at the negedge one cycle after the request edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [2*W-1:0] res, input logic [1:0] err);
        exp_t e;
        int t = 0;
        while (BUSY !== 1'b0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_wait: BUSY=%b after %0d cycles, required 0", BUSY, t);
        end
        OP  = op;
        A   = a;
        B   = b;
        REQ = 1'b1;
        if (push) begin
            e.result = res;
            e.err    = err;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        REQ = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d responses outstanding after %0d cycles, required 0", name, exp_q.size(), t);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({BUSY, VALID, MUL_START, DIV_START} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: BUSY/VALID/MUL_START/DIV_START=%b, required 0000",
                     {BUSY, VALID, MUL_START, DIV_START});
        end
        checks++;
        if (RESULT !== '0 || ERR !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_result: RESULT=%h ERR=%b, required 0000/00", RESULT, ERR);
        end
        checks++;
        if (OPA !== '0 || OPB !== '0) begin
            errors++;
            $display("[TB] FAIL reset_operands: OPA=%h OPB=%h, required 00/00", OPA, OPB);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_add_sub();
        int ms = mul_starts;
        int ds = div_starts;
        issue(OP_ADD, 8'hF0, 8'h20, 1'b1, 16'h0110, ERR_NONE);
        checks++;
        if (VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_latency: VALID=%b one cycle after REQ, required 1", VALID);
        end
        checks++;
        if (OPA !== 8'hF0 || OPB !== 8'h20) begin
            errors++;
            $display("[TB] FAIL add_operands: OPA=%h OPB=%h, required F0/20", OPA, OPB);
        end
        @(negedge CLK);
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_pulse: VALID=%b two cycles after REQ, required 0", VALID);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (RESULT !== 16'h0110) begin
            errors++;
            $display("[TB] FAIL add_hold: RESULT=%h after VALID, required 0110", RESULT);
        end
        issue(OP_SUB, 8'd3, 8'd5, 1'b1, 16'hFFFE, ERR_NONE);
        issue(OP_SUB, 8'd5, 8'd3, 1'b1, 16'h0002, ERR_NONE);
        issue(OP_ADD, 8'hFF, 8'hFF, 1'b1, 16'h01FE, ERR_NONE);
        wait_drain(10, "add_sub_drain");
        checks++;
        if (mul_starts != ms || div_starts != ds) begin
            errors++;
            $display("[TB] FAIL add_sub_no_start: %0d MUL/%0d DIV starts, required 0/0",
                     mul_starts - ms, div_starts - ds);
        end
    endtask

    task automatic test_div();
        int vc = valid_cnt;
        int ds = div_starts;
        issue(OP_DIV, 8'd100, 8'd7, 1'b1, {8'd2, 8'd14}, ERR_NONE);
        wait_drain(60, "div_response");
        checks++;
        if (div_starts != ds + 1) begin
            errors++;
            $display("[TB] FAIL div_start_count: %0d DIV_START pulses, required 1", div_starts - ds);
        end
        checks++;
        if (valid_cnt != vc + 1) begin
            errors++;
            $display("[TB] FAIL div_valid_count: %0d VALID pulses, required 1", valid_cnt - vc);
        end
    endtask

    task automatic test_back_to_back();
        int ds = div_starts;
        issue(OP_DIV, 8'd200, 8'd9, 1'b1, {8'd2, 8'd22}, ERR_NONE);
        repeat (4) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || div_starts != ds) begin
            errors++;
            $display("[TB] FAIL b2b_blocked: BUSY=%b starts=%0d while DONE still high, required 1/0",
                     BUSY, div_starts - ds);
        end
        wait_drain(100, "b2b_response");
        checks++;
        if (div_starts != ds + 1) begin
            errors++;
            $display("[TB] FAIL b2b_start_count: %0d DIV_START pulses, required 1", div_starts - ds);
        end
    endtask

    task automatic test_div0();
        int ds = div_starts;
        issue(OP_DIV, 8'd55, 8'd0, 1'b1, 16'h0000, ERR_DIV0);
        checks++;
        if (VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div0_latency: VALID=%b one cycle after REQ, required 1", VALID);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (div_starts != ds) begin
            errors++;
            $display("[TB] FAIL div0_no_start: %0d DIV_START pulses, required 0", div_starts - ds);
        end
    endtask

    task automatic test_mul();
        int ms = mul_starts;
        issue(OP_MUL, 8'd13, 8'd11, 1'b1, 16'd143, ERR_NONE);
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b1, 16'hFE01, ERR_NONE);
        wait_drain(30, "mul_response");
        checks++;
        if (mul_starts != ms + 2) begin
            errors++;
            $display("[TB] FAIL mul_start_count: %0d MUL_START pulses, required 2", mul_starts - ms);
        end
    endtask

    task automatic test_mul_reset();
        mul_hang = 1'b1;
        issue(OP_MUL, 8'd20, 8'd30, 1'b0, 16'h0000, ERR_NONE);
        repeat (5) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mul_wait_busy: BUSY=%b while MUL outstanding, required 1", BUSY);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({BUSY, VALID, MUL_START, DIV_START} !== 4'b0000 || RESULT !== '0 ||
            ERR !== 2'b00 || OPA !== '0 || OPB !== '0) begin
            errors++;
            $display("[TB] FAIL midop_reset: BUSY=%b VALID=%b RESULT=%h ERR=%b OPA=%h OPB=%h, required all 0",
                     BUSY, VALID, RESULT, ERR, OPA, OPB);
        end
        RST = 1'b0;
        @(negedge CLK);
`ifdef CALC_TIMEOUT_EN
        issue(OP_MUL, 8'd6, 8'd7, 1'b1, 16'h0000, ERR_TMO);
        wait_drain(TMO + 50, "mul_timeout");
`else
        mul_hang = 1'b0;
        issue(OP_MUL, 8'd6, 8'd7, 1'b1, 16'd42, ERR_NONE);
        wait_drain(30, "mul_after_reset");
`endif
        mul_hang = 1'b0;
    endtask

    initial begin
        $display("[TB] calc_op_sequencer bench starting");
        test_reset();
        fork
            monitor();
        join_none
        test_add_sub();
        test_div();
        test_back_to_back();
        test_div0();
        test_mul();
        test_mul_reset();
        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Front-end controller for the calculator arithmetic units.
- Accepts one operation request at a time: opcode plus two operands.
- ADD/SUB are executed internally. MUL and DIV are dispatched to the shared multiplier and divider units through their START/DONE handshakes.
- Captures each unit's result and returns it with a one-cycle VALID pulse. Sits between the keypad/decoder logic and the arithmetic units.

Parameters:
- W, 8, operand width in bits.
- TMO_CYCLES, 255, maximum WAIT-state cycles before timeout (used only with CALC_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  request strobe; sampled only in IDLE.
- OP  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- A  in  W  operand A (dividend for DIV).
- B  in  W  operand B (divisor for DIV).
- BUSY  out  1  high whenever state != IDLE.
- VALID  out  1  one-cycle pulse; RESULT/ERR valid while high.
- RESULT  out  2W  operation result.
- ERR  out  2  00 none, 01 divide-by-zero, 10 timeout.
- OPA  out  W  registered A, driven to both units.
- OPB  out  W  registered B, driven to both units.
- MUL_START  out  1  multiplier start pulse.
- MUL_DONE  in  1  multiplier done level.
- MUL_P  in  2W  multiplier product.
- DIV_START  out  1  divider start pulse.
- DIV_DONE  in  1  divider done level; may stay high for many cycles.
- DIV_Q  in  W  quotient.
- DIV_R  in  W  remainder.

Behaviour:
- Reset: state IDLE. BUSY, VALID, MUL_START, DIV_START = 0. RESULT, ERR, OPA, OPB = 0. done-edge registers = 0.
- States: IDLE, DISPATCH, WAIT, RESP.
- IDLE, REQ=1 at edge n:
  - Latch OP, A→OPA, B→OPB.
  - ADD/SUB: compute at the same edge, go to RESP. VALID is high in cycle n+1.
  - DIV with B==0: go to RESP with ERR=01, RESULT=0, no DIV_START.
  - Otherwise go to DISPATCH.
- DISPATCH: selected unit's DONE high → stay (unit still finishing a previous job). DONE low → assert that unit's START for exactly this one cycle, go to WAIT.
- WAIT:
  - Exit on the rising edge of the selected DONE only (DONE=1 and registered previous DONE=0). A level already high does not count.
  - On exit, RESULT ← MUL_P, or {DIV_R, DIV_Q} for DIV. Go to RESP.
- RESP: VALID=1 for one cycle, then go to IDLE. RESULT and ERR hold until the next VALID.
- Arithmetic:
  - ADD: RESULT = zero-extended A+B; carry lands in bit W.
  - SUB: RESULT = A−B, sign-extended to 2W.
  - Operands are unsigned for MUL/DIV.
- REQ outside IDLE is ignored; there is no queue. Minimum interval between accepted requests is 2 cycles.
- Only one START is ever high, and only in DISPATCH.
- RST mid-operation: return to IDLE immediately with all outputs cleared. A unit left running is not aborted; the DISPATCH guard blocks redispatch until its DONE falls.
- BUSY is combinational from state.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined: an 8-bit+ counter clears on WAIT entry and increments each WAIT cycle. When it reaches TMO_CYCLES, go to RESP with ERR=10 and RESULT=0. The counter also applies while blocked in DISPATCH.
- Undefined: WAIT and DISPATCH block indefinitely. ERR[1] is constant 0, and the counter logic is absent.

Decomposition:
- Package calc_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - error codes ERR_NONE/ERR_DIV0/ERR_TMO;
  - the state encoding.
- The divider/multiplier wrappers share the same package.
- One natural sub-module: calc_timeout_ctr (clear, enable, expired), instantiated only under CALC_TIMEOUT_EN.

Test Plan:
- ADD, A=8'hF0, B=8'h20 → VALID one cycle after REQ, RESULT=16'h0110, ERR=00, no START pulses.
- SUB, A=3, B=5 → RESULT=16'hFFFE, ERR=00.
- DIV, A=100, B=7; model DIV_DONE rising 12 cycles after DIV_START and held 21 cycles → exactly one DIV_START; RESULT={8'd2, 8'd14}; VALID once.
- DIV, B=0 → VALID next cycle, ERR=01, RESULT=0, DIV_START never asserted.
- Back-to-back DIV while model DIV_DONE is still high from the prior job → sequencer holds in DISPATCH; DIV_START only after DONE falls; correct second result.
- RST asserted in WAIT during MUL; then MUL request; with CALC_TIMEOUT_EN and the model never raising DONE → outputs cleared on reset; then ERR=10 after TMO_CYCLES.
